// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if
//   Bundles the multiplexed seven-segment bus and the decoded results of
//   seg_scan_decoder.
//   segEn[3:0]  anode enables, active-low, bit i selects digit i
//   seg[6:0]    cathodes, active-low, seg[0]=a .. seg[6]=g
//   digits      captured BCD, digit i at [4i+3:4i]
//   frame_valid one-cycle pulse per completed four-digit frame
//   secs        digit1*10 + digit0 of the last frame
//   secs_valid  digits 0 and 1 of the last frame were both numeric
//   bad_pattern sticky, an unrecognised cathode pattern was captured
//   overlap_err sticky, two or more anodes were low in one sample
//   master: the display side (drives the bus, observes results)
//   slave:  the decoder (reads the bus, drives results)
interface seg_scan_decoder_if;
  logic [3:0]  segEn;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic        frame_valid;
  logic [6:0]  secs;
  logic        secs_valid;
  logic        bad_pattern;
  logic        overlap_err;

  modport master (
    output segEn,
    output seg,
    input  digits,
    input  frame_valid,
    input  secs,
    input  secs_valid,
    input  bad_pattern,
    input  overlap_err
  );

  modport slave (
    input  segEn,
    input  seg,
    output digits,
    output frame_valid,
    output secs,
    output secs_valid,
    output bad_pattern,
    output overlap_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Passive reader for a multiplexed 4-digit seven-segment bus. Each digit
//   dwell is captured once after SETTLE_CYCLES consecutive identical
//   samples, the cathode pattern is decoded back to BCD, and complete
//   four-digit frames are reported together with the reconstructed seconds.
//   Parameters:
//     SETTLE_CYCLES  identical samples needed before capture (1..255)
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    seg_scan_decoder_if.slave (segEn/seg in, decoded results out)
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_scan_decoder_if.slave    bus
);

  localparam logic [7:0] SETTLE_N = SETTLE_CYCLES[7:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Input stage and previous-sample copy
  logic [3:0]  s_en_reg;
  logic [6:0]  s_seg_reg;

  // Sample classification
  logic [3:0]  en_low;
  logic        en_any;
  logic        en_multi;
  logic        en_single;
  logic        same;

  // Stability counter and FSM
  logic [7:0]  cnt_reg;
  logic [7:0]  cnt_next;
  logic [7:0]  cnt_inc;
  state_t      state_reg;
  state_t      state_next;
  logic        capture;

  // Decode
  logic [3:0]  dec_val;
  logic        dec_bad;
  logic [3:0]  sel;

  // Frame tracking
  logic [15:0] digits_reg;
  logic [15:0] digits_next;
  logic [3:0]  seen_reg;
  logic [3:0]  seen_next;
  logic        frame_done;

  // Seconds
  logic [3:0]  d0;
  logic [3:0]  d1;
  logic        secs_ok;
  logic [6:0]  secs_calc;

  // Result registers
  logic        frame_valid_reg;
  logic [6:0]  secs_reg;
  logic        secs_valid_reg;
  logic        bad_reg;
  logic        overlap_reg;

  // ---------------------------------------------------------------------
  // Sample classification.
  // The sample being registered on an edge is compared with the one already
  // held in s_en_reg/s_seg_reg, so the counter reads 1 one edge after a new
  // value first lands in the input stage and capture falls on edge k+N.
  // ---------------------------------------------------------------------
  assign en_low    = ~bus.segEn;
  assign en_any    = |en_low;
  // x & (x-1) clears the lowest set bit; anything left means 2+ anodes low
  assign en_multi  = |(en_low & (en_low - 4'd1));
  assign en_single = en_any && !en_multi;
  assign same      = ({bus.segEn, bus.seg} == {s_en_reg, s_seg_reg});

  assign cnt_inc = (cnt_reg >= SETTLE_N) ? SETTLE_N : (cnt_reg + 8'd1);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (!en_single) begin
      // Blanking gap or overlapping anodes both abandon the dwell
      state_next = IDLE;
    end else if (!same) begin
      state_next = SETTLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = SETTLE;
        SETTLE:  state_next = (cnt_inc == SETTLE_N) ? HELD : SETTLE;
        HELD:    state_next = HELD;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (counter update and capture strobe)
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_next = 8'd0;
    capture  = 1'b0;
    if (en_single && same) begin
      cnt_next = cnt_inc;
      // Only SETTLE captures, so a held dwell is never captured twice
      capture  = (state_reg == SETTLE) && (cnt_inc == SETTLE_N);
    end
  end

  // ---------------------------------------------------------------------
  // Cathode decode. E is never produced by a valid pattern, so it doubles
  // as the "unrecognised" marker.
  // ---------------------------------------------------------------------
  always_comb begin
    dec_val = 4'hE;
    case (s_seg_reg)
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      7'h7F:   dec_val = 4'hF;
      default: dec_val = 4'hE;
    endcase
  end

  assign dec_bad = (dec_val == 4'hE);

  // During a capture the held sample is single-anode, so this is one-hot
  assign sel = ~s_en_reg;

  // ---------------------------------------------------------------------
  // Digit fields and seen mask
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digits_next[4*gi +: 4] = (capture && sel[gi]) ? dec_val
                                                            : digits_reg[4*gi +: 4];
      assign seen_next[gi]          = seen_reg[gi] | (capture & sel[gi]);
    end
  endgenerate

  assign frame_done = capture && (seen_next == 4'hF);

  // Seconds use the post-capture digit values so the completing digit counts
  assign d0        = digits_next[3:0];
  assign d1        = digits_next[7:4];
  assign secs_ok   = (d1 <= 4'd9) && (d0 <= 4'd9);
  assign secs_calc = secs_ok ? (({3'b000, d1} * 7'd10) + {3'b000, d0}) : 7'd0;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Idle bus values, so the first post-reset sample always counts as a change
      s_en_reg        <= 4'hF;
      s_seg_reg       <= 7'h7F;
      cnt_reg         <= 8'd0;
      digits_reg      <= 16'hFFFF;
      seen_reg        <= 4'h0;
      frame_valid_reg <= 1'b0;
      secs_reg        <= 7'd0;
      secs_valid_reg  <= 1'b0;
      bad_reg         <= 1'b0;
      overlap_reg     <= 1'b0;
    end else begin
      s_en_reg        <= bus.segEn;
      s_seg_reg       <= bus.seg;
      cnt_reg         <= cnt_next;
      digits_reg      <= digits_next;
      seen_reg        <= frame_done ? 4'h0 : seen_next;
      frame_valid_reg <= frame_done;
      if (frame_done) begin
        secs_reg       <= secs_calc;
        secs_valid_reg <= secs_ok;
      end
      if (capture && dec_bad) begin
        bad_reg <= 1'b1;
      end
      if (en_multi) begin
        overlap_reg <= 1'b1;
      end
    end
  end

  assign bus.digits      = digits_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.secs        = secs_reg;
  assign bus.secs_valid  = secs_valid_reg;
  assign bus.bad_pattern = bad_reg;
  assign bus.overlap_err = overlap_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Directed bench for seg_scan_decoder at SETTLE_CYCLES = 4. A table of
//   dwells (anode, cathode, length) with hand-computed expected outputs is
//   applied in order; hand-written sequences cover capture latency and
//   reset in the middle of a frame.
module tb_seg_scan_decoder;

  logic clk = 1'b0;
  logic rst_n;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .SETTLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_err    = 0;
  int fv_count = 0;

  // frame_valid lasts one full cycle, so each pulse is seen at one negedge
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_count++;
  end

  typedef struct {
    logic [3:0]  en;
    logic [6:0]  seg;
    int          cycles;
    logic [15:0] digits;
    int          fv;
    logic [6:0]  secs;
    logic        sv;
    logic        bad;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [3:0] en, logic [6:0] sg, int cycles,
                              logic [15:0] digits, int fv, logic [6:0] secs,
                              logic sv, logic bad, logic ov);
    vec_t v;
    v.en     = en;
    v.seg    = sg;
    v.cycles = cycles;
    v.digits = digits;
    v.fv     = fv;
    v.secs   = secs;
    v.sv     = sv;
    v.bad    = bad;
    v.ov     = ov;
    tbl.push_back(v);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic [3:0] en, logic [6:0] sg);
    bus.segEn = en;
    bus.seg   = sg;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, " digits"},      32'(bus.digits),      32'hFFFF);
    check({tag, " frame_valid"}, 32'(bus.frame_valid), 32'd0);
    check({tag, " secs"},        32'(bus.secs),        32'd0);
    check({tag, " secs_valid"},  32'(bus.secs_valid),  32'd0);
    check({tag, " bad_pattern"}, 32'(bus.bad_pattern), 32'd0);
    check({tag, " overlap_err"}, 32'(bus.overlap_err), 32'd0);
  endtask

  initial begin
    int fv0;

    // en      seg    cyc  digits    fv secs sv bad ov
    // Scan 0,0,5,9
    add(4'b0111, 7'h40, 10, 16'h0FFF, 0, 7'd0,  0, 0, 0);
    add(4'b1011, 7'h40, 10, 16'h00FF, 0, 7'd0,  0, 0, 0);
    add(4'b1101, 7'h12, 10, 16'h005F, 0, 7'd0,  0, 0, 0);
    add(4'b1110, 7'h10, 10, 16'h0059, 1, 7'd59, 1, 0, 0);
    // Scan 1,2,3,blank
    add(4'b0111, 7'h79, 10, 16'h1059, 0, 7'd59, 1, 0, 0);
    add(4'b1011, 7'h24, 10, 16'h1259, 0, 7'd59, 1, 0, 0);
    add(4'b1101, 7'h30, 10, 16'h1239, 0, 7'd59, 1, 0, 0);
    add(4'b1110, 7'h7F, 10, 16'h123F, 1, 7'd0,  0, 0, 0);
    // Scan 4,6,<0x55>,8
    add(4'b0111, 7'h19, 10, 16'h423F, 0, 7'd0,  0, 0, 0);
    add(4'b1011, 7'h02, 10, 16'h463F, 0, 7'd0,  0, 0, 0);
    add(4'b1101, 7'h55, 10, 16'h46EF, 0, 7'd0,  0, 1, 0);
    add(4'b1110, 7'h00, 10, 16'h46E8, 1, 7'd0,  0, 1, 0);
    // Good scan 0,1,4,2: bad_pattern stays set
    add(4'b0111, 7'h40, 10, 16'h06E8, 0, 7'd0,  0, 1, 0);
    add(4'b1011, 7'h79, 10, 16'h01E8, 0, 7'd0,  0, 1, 0);
    add(4'b1101, 7'h19, 10, 16'h0148, 0, 7'd0,  0, 1, 0);
    add(4'b1110, 7'h24, 10, 16'h0142, 1, 7'd42, 1, 1, 0);
    // Blanking gap, then 4-cycle dwell (ignored) and 5-cycle dwell (captured)
    add(4'b1111, 7'h7F, 5,  16'h0142, 0, 7'd42, 1, 1, 0);
    add(4'b1011, 7'h78, 4,  16'h0142, 0, 7'd42, 1, 1, 0);
    add(4'b1111, 7'h7F, 2,  16'h0142, 0, 7'd42, 1, 1, 0);
    add(4'b1011, 7'h78, 5,  16'h0742, 0, 7'd42, 1, 1, 0);
    add(4'b1111, 7'h7F, 2,  16'h0742, 0, 7'd42, 1, 1, 0);
    // Two anodes low
    add(4'b1100, 7'h40, 6,  16'h0742, 0, 7'd42, 1, 1, 1);
    add(4'b1111, 7'h7F, 2,  16'h0742, 0, 7'd42, 1, 1, 1);

    // Reset
    rst_n = 1'b0;
    drive(4'b1111, 7'h7F);
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    foreach (tbl[i]) begin
      fv0 = fv_count;
      drive(tbl[i].en, tbl[i].seg);
      tick(tbl[i].cycles);
      check($sformatf("v%0d digits", i),      32'(bus.digits),      32'(tbl[i].digits));
      check($sformatf("v%0d frame_valid", i), 32'(fv_count - fv0),  32'(tbl[i].fv));
      check($sformatf("v%0d secs", i),        32'(bus.secs),        32'(tbl[i].secs));
      check($sformatf("v%0d secs_valid", i),  32'(bus.secs_valid),  32'(tbl[i].sv));
      check($sformatf("v%0d bad_pattern", i), 32'(bus.bad_pattern), 32'(tbl[i].bad));
      check($sformatf("v%0d overlap_err", i), 32'(bus.overlap_err), 32'(tbl[i].ov));
      $display("vec %0d: en=%b seg=%h cyc=%0d -> digits=%h pulses=%0d secs=%0d sv=%b bad=%b ov=%b",
               i, tbl[i].en, tbl[i].seg, tbl[i].cycles, bus.digits, fv_count - fv0,
               bus.secs, bus.secs_valid, bus.bad_pattern, bus.overlap_err);
    end

    // Capture latency: new value registered at edge k, field updates at k+4
    drive(4'b1101, 7'h02);
    tick(4);
    check("latency k+3 digits", 32'(bus.digits), 32'h0742);
    tick(1);
    check("latency k+4 digits", 32'(bus.digits), 32'h0762);
    tick(3);
    check("latency held digits", 32'(bus.digits), 32'h0762);
    drive(4'b1111, 7'h7F);
    tick(2);
    $display("seq latency: digits=%h", bus.digits);

    // Digits 2,1,0 seen; capture digit 0 without completing a frame
    fv0 = fv_count;
    drive(4'b1110, 7'h30);
    tick(10);
    check("partial digits", 32'(bus.digits), 32'h0763);
    check("partial no pulse", 32'(fv_count - fv0), 32'd0);

    // Reset mid-dwell on digit 3
    drive(4'b0111, 7'h40);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid-dwell reset");
    tick(3);
    check_reset_vals("held reset");
    rst_n = 1'b1;
    fv0 = fv_count;
    tick(4);
    check("post-reset k+3 digits", 32'(bus.digits), 32'hFFFF);
    tick(1);
    check("post-reset k+4 digits", 32'(bus.digits), 32'h0FFF);
    tick(5);
    drive(4'b1011, 7'h40);
    tick(10);
    drive(4'b1101, 7'h79);
    tick(10);
    check("post-reset 3 digits", 32'(bus.digits), 32'h001F);
    check("post-reset no pulse", 32'(fv_count - fv0), 32'd0);
    drive(4'b1110, 7'h02);
    tick(10);
    check("post-reset frame digits", 32'(bus.digits),      32'h0016);
    check("post-reset frame pulse",  32'(fv_count - fv0),  32'd1);
    check("post-reset secs",         32'(bus.secs),        32'd16);
    check("post-reset secs_valid",   32'(bus.secs_valid),  32'd1);
    check("post-reset bad_pattern",  32'(bus.bad_pattern), 32'd0);
    check("post-reset overlap_err",  32'(bus.overlap_err), 32'd0);
    $display("seq reset: digits=%h secs=%0d sv=%b", bus.digits, bus.secs, bus.secs_valid);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
